// File: rtl/core_sched_pkg.sv
// Shared types and default sizing for the compute-core scheduler.
package core_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_RUN,
    S_DONE,
    S_ABORT
  } sched_state_t;

  localparam int DEF_NREQ    = 2;
  localparam int DEF_W       = 32;
  localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int j;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_idx = '0;
    j       = 0;
    // Walk from the farthest offset down so the nearest valid index is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) gnt_idx = IDX_W'(j);
    end
    any        = |req;
    gnt_onehot = '0;
    gnt_onehot[gnt_idx] = any;
  end

endmodule

// File: rtl/core_scheduler.sv
// Round-robin sharing of one signed compute core between NREQ operand sources,
// with start/busy job tracking and a watchdog that aborts stuck jobs.
module core_scheduler
  import core_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int CNT_W  = $clog2(TIMEOUT + 1),
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a0,
  input  logic [NREQ*W-1:0] req_a1,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      core_a0,
  output logic [W-1:0]      core_a1,
  output logic              core_start,
  input  logic              core_busy,
  output logic              core_abort,
  output logic              done_valid,
  output logic [IDX_W-1:0]  done_id,
  output logic              timeout_err,
  input  logic              clr_err
);

  sched_state_t     state, state_next;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] wdog;
  logic [NREQ-1:0]  gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;
  logic             any;
  logic             wdog_last;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign wdog_last = (wdog == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      core_a0     <= '0;
      core_a1     <= '0;
      done_id     <= '0;
      ptr         <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else if (ena) begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (any) begin
            core_a0 <= req_a0[gnt_idx*W +: W];
            core_a1 <= req_a1[gnt_idx*W +: W];
            done_id <= gnt_idx;
            ptr     <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          end
        end
        S_ISSUE:           wdog <= '0;
        S_WAIT_ACK, S_RUN: wdog <= wdog + CNT_W'(1);
        default: ;
      endcase
      // A watchdog expiry outranks a simultaneous clear request.
      if (state == S_ABORT)  timeout_err <= 1'b1;
      else if (clr_err)      timeout_err <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    core_start = 1'b0;
    core_abort = 1'b0;
    done_valid = 1'b0;
    if (ena) begin
      case (state)
        S_IDLE: begin
          if (any) begin
            req_ready  = gnt_onehot;
            state_next = S_ISSUE;
          end
        end
        S_ISSUE: begin
          core_start = 1'b1;
          state_next = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (core_busy)      state_next = S_RUN;
          else if (wdog_last) state_next = S_ABORT;
        end
        S_RUN: begin
          // Completion beats expiry when both land in the same cycle.
          if (!core_busy)     state_next = S_DONE;
          else if (wdog_last) state_next = S_ABORT;
        end
        S_DONE: begin
          done_valid = 1'b1;
          state_next = S_IDLE;
        end
        S_ABORT: begin
          core_abort = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler (NREQ=2, W=32, TIMEOUT=16); the core is modelled by driving core_busy by hand.
module tb_core_scheduler;

  localparam int NREQ    = 2;
  localparam int W       = 32;
  localparam int TIMEOUT = 16;
  localparam int IDX_W   = 1;
  // Cycles from the core_start cycle to the core_abort cycle: TIMEOUT watchdog cycles plus the ABORT transition.
  localparam int ABORT_EDGES = TIMEOUT + 1;

  logic              clk = 1'b0;
  logic              rst, ena, core_busy, clr_err;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a0, req_a1;
  logic [W-1:0]      core_a0, core_a1;
  logic              core_start, core_abort, done_valid, timeout_err;
  logic [IDX_W-1:0]  done_id;

  int n_tests = 0;
  int n_fail  = 0;

  core_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .req_valid   (req_valid),
    .req_a0      (req_a0),
    .req_a1      (req_a1),
    .req_ready   (req_ready),
    .core_a0     (core_a0),
    .core_a1     (core_a1),
    .core_start  (core_start),
    .core_busy   (core_busy),
    .core_abort  (core_abort),
    .done_valid  (done_valid),
    .done_id     (done_id),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a0, input logic [W-1:0] a1);
    req_a0[i*W +: W] = a0;
    req_a1[i*W +: W] = a1;
  endtask

  // Starts in an IDLE cycle with requests already driven; ends in the IDLE cycle after DONE.
  task automatic run_job(input string tag, input int idx, input logic [W-1:0] a0,
                         input logic [W-1:0] a1, input int busy_cycles);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(oh));
    check({tag, "_nostart"}, 64'(core_start), 64'd0);
    tick();
    check({tag, "_start"}, 64'(core_start), 64'd1);
    check({tag, "_a0"}, 64'(core_a0), 64'(a0));
    check({tag, "_a1"}, 64'(core_a1), 64'(a1));
    check({tag, "_id"}, 64'(done_id), 64'(idx));
    tick();
    check({tag, "_start_once"}, 64'(core_start), 64'd0);
    core_busy = 1'b1;
    repeat (busy_cycles) tick();
    core_busy = 1'b0;
    #1;
    check({tag, "_done_early"}, 64'(done_valid), 64'd0);
    check({tag, "_ready_ignored"}, 64'(req_ready), 64'd0);
    tick();
    check({tag, "_done"}, 64'(done_valid), 64'd1);
    check({tag, "_done_id"}, 64'(done_id), 64'(idx));
    tick();
    check({tag, "_done_once"}, 64'(done_valid), 64'd0);
  endtask

  // Called in the core_start cycle (or later); counts edges until core_abort, bounded.
  task automatic wait_abort(input string tag, input int exp_edges);
    int n;
    int dv;
    bit seen;
    n = 0; dv = 0; seen = 1'b0;
    for (int i = 1; i <= 4 * TIMEOUT && !seen; i++) begin
      tick();
      if (done_valid) dv++;
      if (core_abort) begin
        seen = 1'b1;
        n = i;
      end
    end
    check({tag, "_abort_edges"}, 64'(n), 64'(exp_edges));
    check({tag, "_no_done"}, 64'(dv), 64'd0);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; core_busy = 1'b0; clr_err = 1'b0;
    req_valid = '0; req_a0 = '0; req_a1 = '0;

    // Reset state
    tick(); tick();
    check("rst_a0", 64'(core_a0), 64'd0);
    check("rst_a1", 64'(core_a1), 64'd0);
    check("rst_id", 64'(done_id), 64'd0);
    check("rst_err", 64'(timeout_err), 64'd0);
    check("rst_pulses", {61'd0, core_start, core_abort, done_valid}, 64'd0);
    rst = 1'b0;

    // Single requester 0: a0=5, a1=-3, busy for 10 cycles
    set_ops(0, 32'd5, 32'hFFFF_FFFD);
    req_valid = 2'b01;
    #1;
    check("t1_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    check("t1_start", 64'(core_start), 64'd1);
    check("t1_a0", 64'(core_a0), 64'd5);
    check("t1_a1", 64'(core_a1), 64'hFFFF_FFFD);
    tick();
    core_busy = 1'b1;
    repeat (10) tick();
    core_busy = 1'b0;
    #1;
    check("t1_done_early", 64'(done_valid), 64'd0);
    tick();
    check("t1_done", 64'(done_valid), 64'd1);
    check("t1_done_id", 64'(done_id), 64'd0);
    check("t1_err", 64'(timeout_err), 64'd0);
    tick();

    // Both requesters valid continuously: grants 0,1,0,1 after a pointer reset
    rst = 1'b1; tick(); rst = 1'b0;
    set_ops(0, 32'd11, 32'hFFFF_FFEA);
    set_ops(1, 32'd33, 32'hFFFF_FFD4);
    req_valid = 2'b11;
    run_job("rr0", 0, 32'd11, 32'hFFFF_FFEA, 2);
    run_job("rr1", 1, 32'd33, 32'hFFFF_FFD4, 3);
    set_ops(0, 32'd55, 32'h8000_0000);
    set_ops(1, 32'h7FFF_FFFF, 32'd0);
    run_job("rr2", 0, 32'd55, 32'h8000_0000, 1);
    run_job("rr3", 1, 32'h7FFF_FFFF, 32'd0, 2);
    req_valid = 2'b00;

    // Core never raises busy
    set_ops(0, 32'd1, 32'd2);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    check("to_start", 64'(core_start), 64'd1);
    wait_abort("to", ABORT_EDGES);
    check("to_err_in_abort", 64'(timeout_err), 64'd0);
    tick();
    check("to_err_set", 64'(timeout_err), 64'd1);
    check("to_abort_once", 64'(core_abort), 64'd0);
    set_ops(1, 32'd9, 32'hFFFF_FFF7);
    req_valid = 2'b10;
    run_job("to_next", 1, 32'd9, 32'hFFFF_FFF7, 2);
    req_valid = 2'b00;
    check("to_err_sticky", 64'(timeout_err), 64'd1);

    // Busy stuck high; clr_err during the ABORT cycle loses to the set
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    check("stk_start", 64'(core_start), 64'd1);
    core_busy = 1'b1;
    wait_abort("stk", ABORT_EDGES);
    clr_err = 1'b1;
    core_busy = 1'b0;
    tick();
    clr_err = 1'b0;
    check("stk_set_wins", 64'(timeout_err), 64'd1);
    set_ops(1, 32'd4, 32'd6);
    req_valid = 2'b10;
    run_job("stk_good", 1, 32'd4, 32'd6, 1);
    req_valid = 2'b00;
    check("stk_err_kept", 64'(timeout_err), 64'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err", 64'(timeout_err), 64'd0);

    // ena low for 5 cycles during RUN while busy falls
    set_ops(0, 32'd9, 32'hFFFF_FFFF);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    core_busy = 1'b1;
    tick(); tick();
    ena = 1'b0;
    core_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_no_done", 64'(done_valid), 64'd0);
    end
    ena = 1'b1;
    #1;
    check("frz_first_ena", 64'(done_valid), 64'd0);
    tick();
    check("frz_done", 64'(done_valid), 64'd1);
    check("frz_done_id", 64'(done_id), 64'd0);
    tick();

    // ena low for 5 cycles in WAIT_ACK delays the watchdog by 5 cycles
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    check("wfz_start", 64'(core_start), 64'd1);
    repeat (3) tick();
    ena = 1'b0;
    repeat (5) tick();
    ena = 1'b1;
    wait_abort("wfz", ABORT_EDGES + 5 - 8);
    tick();
    check("wfz_err", 64'(timeout_err), 64'd1);

    // rst pulsed during RUN (pointer is 1 beforehand)
    set_ops(0, 32'd77, 32'hFFFF_FFF7);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    core_busy = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("mr_a0", 64'(core_a0), 64'd0);
    check("mr_a1", 64'(core_a1), 64'd0);
    check("mr_id", 64'(done_id), 64'd0);
    check("mr_err", 64'(timeout_err), 64'd0);
    check("mr_pulses", {61'd0, core_start, core_abort, done_valid}, 64'd0);
    rst = 1'b0;
    core_busy = 1'b0;
    req_valid = 2'b11;
    #1;
    check("mr_ptr0", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    check("mr_start", 64'(core_start), 64'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
